// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared types and constants for the LEGv8 fetch stage
package legv8_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_FAULT = 2'b10
  } fetch_state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

endpackage

// File: rtl/legv8_fetch_unit_if.sv
// rtl/legv8_fetch_unit_if.sv - instruction memory read bus between fetch unit and memory
interface legv8_fetch_unit_if;
  import legv8_pkg::*;

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/legv8_pc_next.sv
// rtl/legv8_pc_next.sv - next-PC select (sequential or redirect) with word-alignment check
module legv8_pc_next
  import legv8_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misaligned
);

  logic [ADDR_W-1:0] w_seq_pc;

  // Sequential successor wraps modulo 2^64; no carry out is kept.
  assign w_seq_pc   = pc + ADDR_W'(4);
  assign next_pc    = redirect ? branch_target : w_seq_pc;
  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/legv8_fetch_unit.sv
// rtl/legv8_fetch_unit.sv - PC register, instruction memory fetch FSM and instruction register
module legv8_fetch_unit
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          CNT_W          = 8
) (
  input  logic               clock,
  input  logic               reset,
  legv8_fetch_unit_if.master mem,
  input  logic               advance,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               fault,
  output logic [1:0]         fault_code
);

  fetch_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]         r_fc, w_fc_nxt;
  logic               w_req;
  logic               w_valid;
  logic [ADDR_W-1:0]  w_next_pc;
  logic               w_misaligned;

  legv8_pc_next u_pc_next (
    .pc            (r_pc),
    .redirect      (redirect),
    .branch_target (branch_target),
    .next_pc       (w_next_pc),
    .misaligned    (w_misaligned)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_cnt   <= '0;
      r_fc    <= FC_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fc    <= w_fc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_cnt_nxt   = r_cnt;
    w_fc_nxt    = r_fc;
    w_req       = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_req = 1'b1;
        if (mem.mem_ack) begin
          w_instr_nxt = mem.mem_rdata;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          // The counter value seen here is the number of unacked cycles already spent.
          if (TIMEOUT_CYCLES != 0 && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt = ST_FAULT;
            w_fc_nxt    = FC_TIMEOUT;
          end
        end
      end
      ST_HOLD: begin
        w_valid = 1'b1;
        if (advance) begin
          if (w_misaligned) begin
            w_state_nxt = ST_FAULT;
            w_fc_nxt    = FC_MISALIGN;
          end else begin
            w_pc_nxt    = w_next_pc;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_FAULT;
      end
    endcase
  end

  assign mem.mem_req  = w_req;
  assign mem.mem_addr = r_pc;
  assign instruction  = r_instr;
  assign instr_valid  = w_valid;
  assign pc           = r_pc;
  assign fault        = (r_state == ST_FAULT);
  assign fault_code   = r_fc;

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// tb/tb_legv8_fetch_unit.sv - self-checking bench for legv8_fetch_unit against a behavioural model
module tb_legv8_fetch_unit;
  import legv8_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        advance = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] pc;
  logic        fault;
  logic [1:0]  fault_code;

  legv8_fetch_unit_if mem_if ();

  legv8_fetch_unit #(
    .RESET_PC       (64'h0),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mem           (mem_if.master),
    .advance       (advance),
    .redirect      (redirect),
    .branch_target (branch_target),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .fault         (fault),
    .fault_code    (fault_code)
  );

  always #5 clock = ~clock;

  // Behavioural view: waiting on memory, holding a word, or dead until reset.
  bit          m_busy;
  bit          m_dead;
  logic [1:0]  m_code;
  logic [63:0] m_pc;
  logic [31:0] m_ir;
  int          m_waited;
  int          wleft;
  int          fixed_lat;
  logic [31:0] data_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          reqs;
  int          dead_cycles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_lat();
    if (fixed_lat >= 0) return fixed_lat;
    if ($urandom_range(0, 63) == 0) return 20;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    m_busy   = 1'b1;
    m_dead   = 1'b0;
    m_code   = 2'b00;
    m_pc     = 64'h0;
    m_ir     = 32'h0;
    m_waited = 0;
    wleft    = pick_lat();
  endtask

  task automatic model_edge();
    logic [63:0] tgt;
    if (m_dead) begin
    end else if (m_busy) begin
      if (mem_if.mem_ack) begin
        m_ir     = mem_if.mem_rdata;
        m_busy   = 1'b0;
        m_waited = 0;
      end else begin
        m_waited++;
        if (m_waited == 16) begin
          m_dead = 1'b1;
          m_code = 2'b10;
        end
      end
    end else if (advance) begin
      tgt = redirect ? branch_target : m_pc + 64'd4;
      if (tgt % 4 != 0) begin
        m_dead = 1'b1;
        m_code = 2'b01;
      end else begin
        m_pc   = tgt;
        m_busy = 1'b1;
        wleft  = pick_lat();
      end
    end
  endtask

  task automatic compare();
    check("mem_req", mem_if.mem_req, m_busy && !m_dead);
    check("mem_addr", mem_if.mem_addr, m_pc);
    check("instr_valid", instr_valid, !m_busy && !m_dead);
    check("instruction", instruction, m_ir);
    check("pc", pc, m_pc);
    check("fault", fault, m_dead);
    check("fault_code", fault_code, m_code);
  endtask

  task automatic mem_drive();
    if (m_busy && !m_dead) begin
      if (wleft == 0) begin
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = (data_q.size() != 0) ? data_q.pop_front() : $urandom;
      end else begin
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = $urandom;
        wleft--;
      end
    end else begin
      mem_if.mem_ack   = 1'($urandom_range(0, 1));
      mem_if.mem_rdata = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare();
    mem_drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare();
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    compare();
    mem_drive();
  endtask

  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 32'h0;

    // Reset release and first fetch with a one-cycle memory
    fixed_lat = 0;
    data_q.push_back(32'h8B1F0040);
    do_reset();
    check("t1_req", mem_if.mem_req, 1'b1);
    check("t1_addr", mem_if.mem_addr, 64'h0);
    step();
    check("t1_instr", instruction, 32'h8B1F0040);
    check("t1_valid", instr_valid, 1'b1);
    check("t1_req_low", mem_if.mem_req, 1'b0);
    check("t1_pc", pc, 64'h0);

    // Sequential advance, three wait states
    fixed_lat = 3;
    data_q.push_back(32'hCB0003E0);
    advance = 1'b1;
    redirect = 1'b0;
    step();
    advance = 1'b0;
    check("t2_addr", mem_if.mem_addr, 64'h4);
    reqs = 0;
    while (mem_if.mem_req && reqs < 40) begin
      reqs++;
      step();
    end
    check("t2_req_cycles", 64'(reqs), 64'd4);
    check("t2_instr", instruction, 32'hCB0003E0);
    check("t2_pc", pc, 64'h4);
    check("t2_valid", instr_valid, 1'b1);

    // Aligned redirect, then asynchronous reset while the ack is pending
    fixed_lat = 0;
    advance = 1'b1;
    redirect = 1'b1;
    branch_target = 64'h100;
    step();
    advance = 1'b0;
    redirect = 1'b0;
    check("t3_addr", mem_if.mem_addr, 64'h100);
    check("t3_req", mem_if.mem_req, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_valid", instr_valid, 1'b0);
    check("t5_instr", instruction, 32'h0);
    check("t5_fault", fault, 1'b0);
    check("t5_pc", pc, 64'h0);
    do_reset();
    check("t5_req", mem_if.mem_req, 1'b1);
    step();
    advance = 1'b1;
    step();
    advance = 1'b0;
    step();

    // Misaligned redirect from pc=4 is fatal until reset
    advance = 1'b1;
    redirect = 1'b1;
    branch_target = 64'h102;
    step();
    advance = 1'b0;
    redirect = 1'b0;
    check("t3_fault", fault, 1'b1);
    check("t3_code", fault_code, 2'b01);
    check("t3_pc", pc, 64'h4);
    repeat (10) begin
      advance = 1'($urandom_range(0, 1));
      redirect = 1'($urandom_range(0, 1));
      branch_target = {$urandom, $urandom} & ~64'h3;
      step();
    end
    check("t3_req_dead", mem_if.mem_req, 1'b0);
    advance = 1'b0;

    // Fetch timeout with memory never answering
    fixed_lat = 1000;
    do_reset();
    reqs = 0;
    while (mem_if.mem_req && reqs < 40) begin
      reqs++;
      step();
    end
    check("t4_req_cycles", 64'(reqs), 64'd16);
    check("t4_fault", fault, 1'b1);
    check("t4_code", fault_code, 2'b10);
    mem_if.mem_ack = 1'b1;
    step();
    mem_if.mem_ack = 1'b1;
    step();
    check("t4_code_held", fault_code, 2'b10);

    // PC wrap at the top of the address space
    fixed_lat = 0;
    do_reset();
    step();
    advance = 1'b1;
    redirect = 1'b1;
    branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    advance = 1'b0;
    redirect = 1'b0;
    step();
    check("t6_pc_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    fixed_lat = 3;
    advance = 1'b1;
    step();
    check("t6_pc_wrap", pc, 64'h0);
    check("t6_addr", mem_if.mem_addr, 64'h0);
    check("t6_nofault", fault, 1'b0);
    repeat (3) begin
      advance = ~advance;
      redirect = 1'($urandom_range(0, 1));
      branch_target = {$urandom, $urandom};
      step();
    end
    advance = 1'b0;
    step();
    check("t6_pc_hold", pc, 64'h0);
    check("t6_valid", instr_valid, 1'b1);

    // Randomized traffic
    fixed_lat = -1;
    do_reset();
    dead_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      advance = 1'($urandom_range(0, 1));
      redirect = 1'($urandom_range(0, 1));
      branch_target = {$urandom, $urandom};
      if ($urandom_range(0, 15) != 0) branch_target[1:0] = 2'b00;
      step();
      if (m_dead) dead_cycles++;
      if (dead_cycles > 3 || $urandom_range(0, 255) == 0) begin
        dead_cycles = 0;
        #2;
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
